inbound_packet_assembler: RTL and testbench



---
 rtl/inbound_packet_assembler.sv | 167 ++++++++++++++++
 tb/tb_inbound_packet_assembler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inbound_packet_assembler.sv
// inbound_packet_assembler
// Collects a serial byte stream into 4-byte packets (first byte lands in
// pkt[3]) and hands each finished packet to the output-buffer FIFO with a
// single-cycle pkt_avail strobe. While a packet waits on a full FIFO the source
// is held off with in_ready=0. Byte streams that stall for more than GAP_LIMIT
// idle cycles are aborted with a one-cycle pkt_err pulse.
//
// Optional build macro: INBOUND_CHECKSUM_EN
//   When defined, pkt[0] carries pkt[3]^pkt[2]^pkt[1]. The check is made as
//   the fourth byte arrives; a bad packet is dropped (no pkt_avail), pkt_err
//   pulses in the first DELIVER cycle and the FSM returns to IDLE.

module inbound_packet_assembler #(
  parameter int GAP_LIMIT = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      payload_inbound,
  input  logic            put_inbound,
  input  logic            ob_full,
  output logic            in_ready,
  output logic [3:0][7:0] pkt,
  output logic            pkt_avail,
  output logic            pkt_err
);

  // Gap counter must be able to hold GAP_LIMIT+1.
  localparam int GW = $clog2(GAP_LIMIT + 2);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DELIVER = 2'd2
  } state_e;

  state_e          state_q,    state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]   gap_cnt_q,  gap_cnt_d;
  logic [3:0][7:0] pkt_q,      pkt_d;
  logic            err_q,      err_d;
  logic            drop_q,     drop_d;

  logic            accept_s;
  logic            csum_bad_s;

`ifdef INBOUND_CHECKSUM_EN
  // XOR of the three data bytes already captured in pkt[3..1].
  function automatic logic [7:0] csum_f(input logic [3:0][7:0] p);
    csum_f = p[3] ^ p[2] ^ p[1];
  endfunction

  // Compare the arriving fourth byte against the captured data bytes.
  always_comb begin
    csum_bad_s = (csum_f(pkt_q) != payload_inbound);
  end
`else
  // Without the checksum feature no packet is ever considered bad.
  always_comb begin
    csum_bad_s = 1'b0;
  end
`endif

  // A byte is taken only while the block advertises readiness.
  always_comb begin
    accept_s = put_inbound && in_ready;
  end

  // Next-state and output decode for the assembler FSM.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pkt_d      = pkt_q;
    err_d      = 1'b0;
    drop_d     = drop_q;
    in_ready   = 1'b1;
    pkt_avail  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (put_inbound) begin
          pkt_d[3]   = payload_inbound;
          byte_cnt_d = 2'd1;
          gap_cnt_d  = '0;
          drop_d     = 1'b0;
          state_d    = S_COLLECT;
        end else begin
          byte_cnt_d = 2'd0;
          gap_cnt_d  = '0;
        end
      end

      S_COLLECT: begin
        if (accept_s) begin
          pkt_d[2'd3 - byte_cnt_q] = payload_inbound;
          gap_cnt_d = '0;
          if (byte_cnt_q == 2'd3) begin
            // Fourth byte: packet complete, checksum decided right here.
            byte_cnt_d = 2'd0;
            drop_d     = csum_bad_s;
            err_d      = csum_bad_s;
            state_d    = S_DELIVER;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (gap_cnt_q == GAP_MAX) begin
          // Stream stalled one cycle too long: abandon the partial packet.
          err_d      = 1'b1;
          byte_cnt_d = 2'd0;
          gap_cnt_d  = '0;
          state_d    = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      S_DELIVER: begin
        in_ready = 1'b0;
        if (drop_q) begin
          // Bad checksum: discard without strobing the FIFO.
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!ob_full) begin
          pkt_avail = 1'b1;
          state_d   = S_IDLE;
        end else begin
          // FIFO full: hold the packet unchanged and keep the source off.
          state_d = S_DELIVER;
        end
      end

      default: begin
        byte_cnt_d = 2'd0;
        gap_cnt_d  = '0;
        drop_d     = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State, counters and packet register; reset discards any packet in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      gap_cnt_q  <= '0;
      pkt_q      <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pkt_q      <= pkt_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end

  // Registered packet data and error pulse drive the outputs directly.
  always_comb begin
    pkt     = pkt_q;
    pkt_err = err_q;
  end

endmodule

// File: tb/tb_inbound_packet_assembler.sv
// Testbench for inbound_packet_assembler (GAP_LIMIT=2).
// A driver issues packet attempts (bytes plus inter-byte idle gaps) and pushes
// the outcome predicted from the packet rules into a scoreboard queue; a
// monitor pops and compares on every pkt_avail or pkt_err.

module tb_inbound_packet_assembler;

  localparam int G = 2;

  logic            clock;
  logic            reset;
  logic [7:0]      payload_inbound;
  logic            put_inbound;
  logic            ob_full;
  logic            in_ready;
  logic [3:0][7:0] pkt;
  logic            pkt_avail;
  logic            pkt_err;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;

  inbound_packet_assembler #(.GAP_LIMIT(G)) dut (
    .clock           (clock),
    .reset           (reset),
    .payload_inbound (payload_inbound),
    .put_inbound     (put_inbound),
    .ob_full         (ob_full),
    .in_ready        (in_ready),
    .pkt             (pkt),
    .pkt_avail       (pkt_avail),
    .pkt_err         (pkt_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic step(input logic put, input logic [7:0] d, input logic full);
    @(posedge clock);
    #1;
    put_inbound     = put;
    payload_inbound = d;
    ob_full         = full;
    @(negedge clock);
  endtask

  // Outcome of one attempt from the packet rules.
  task automatic push_expect(input logic [31:0] w, input int abort_j);
    exp_t e;
    logic bad;
    bad = 1'b0;
`ifdef INBOUND_CHECKSUM_EN
    bad = (w[7:0] != (w[31:24] ^ w[23:16] ^ w[15:8]));
`endif
    e.is_err = (abort_j != 0) || bad;
    e.data   = w;
    exp_q.push_back(e);
  endtask

  // One packet attempt: bytes w[31:24]..w[7:0], idle gaps after bytes 1..3,
  // full_hold = cycles of ob_full=1 in DELIVER (-1: random).
  task automatic send_attempt(input logic [31:0] w, input int g1, input int g2,
                              input int g3, input int full_hold);
    int   gaps[3];
    int   abort_j;
    logic drop;
    logic full;
    logic done;
    gaps    = '{g1, g2, g3};
    abort_j = 0;
    for (int k = 0; k < 3; k++) begin
      if (abort_j == 0 && gaps[k] > G) abort_j = k + 1;
    end
    drop = 1'b0;
`ifdef INBOUND_CHECKSUM_EN
    drop = (w[7:0] != (w[31:24] ^ w[23:16] ^ w[15:8]));
`endif
    push_expect(w, abort_j);
    for (int j = 0; j < 4; j++) begin
      step(1'b1, w[31-8*j -: 8], 1'($urandom_range(0, 1)));
      chk("in_ready_on_byte", 32'(in_ready), 32'd1);
      if (j == 3) break;
      for (int i = 1; i <= gaps[j]; i++) begin
        step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
        chk("pkt_err_gap_timing", 32'(pkt_err), 32'(i == G + 2));
      end
      if (abort_j == j + 1) return;
    end
    done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (full_hold >= 0) full = (n < full_hold);
      else                full = (n < 8) && ($urandom_range(0, 2) == 0);
      // Garbage byte offered while not ready must be ignored.
      step(1'b1, 8'($urandom), full);
      chk("in_ready_low_in_deliver", 32'(in_ready), 32'd0);
      chk("pkt_held_in_deliver", pkt, w);
      if (drop) begin
        chk("no_avail_on_drop", 32'(pkt_avail), 32'd0);
        done = 1'b1;
        break;
      end
      chk("pkt_avail_vs_full", 32'(pkt_avail), 32'(!full));
      if (pkt_avail) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      fails++;
      $display("FAIL deliver_timeout: got no strobe, expected one within 40 cycles");
    end
  endtask

  // Scoreboard monitor: every strobe or error pulse consumes one expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (pkt_avail) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_avail: got pkt %h, expected no output", pkt);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_err || pkt !== mon_e.data) begin
            fails++;
            $display("FAIL avail_data: got pkt %h, expected %s %h", pkt,
                     mon_e.is_err ? "error" : "packet", mon_e.data);
          end
        end
        checks++;
        if (ob_full !== 1'b0) begin
          fails++;
          $display("FAIL avail_while_full: got ob_full %b, expected 0", ob_full);
        end
      end
      if (pkt_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_err: got pkt_err 1, expected no output");
        end else begin
          mon_e = exp_q.pop_front();
          if (!mon_e.is_err) begin
            fails++;
            $display("FAIL err_vs_packet: got pkt_err, expected packet %h", mon_e.data);
          end
        end
      end
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    int g[3];
    reset           = 1'b1;
    put_inbound     = 1'b0;
    payload_inbound = 8'h00;
    ob_full         = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pkt", pkt, 32'h0);
    chk("rst_avail", 32'(pkt_avail), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err", 32'(pkt_err), 32'd0);
    reset = 1'b0;

    // Reset in DELIVER while the FIFO is full discards the packet.
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'hD4, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    chk("pre_rst_avail", 32'(pkt_avail), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    #1;
    reset   = 1'b1;
    ob_full = 1'b0;
    #1;
    chk("async_rst_pkt", pkt, 32'h0);
    chk("async_rst_avail", 32'(pkt_avail), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_err", 32'(pkt_err), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Directed cases.
    send_attempt(32'hA1B2C3D4, 0, 0, 0, 0);
    send_attempt(32'hA1B2C3D4, 0, 0, 0, 6);
    send_attempt(32'h11223344, 0, 2, 0, 0);
    send_attempt(32'h11223344, 0, 3, 0, 0);
    send_attempt(32'h55667788, 1, 4, 0, 0);
    send_attempt(32'h01020407, 0, 0, 0, 2);
    send_attempt(32'h01020400, 0, 0, 0, 0);

    // Randomized attempts.
    for (int a = 0; a < 150; a++) begin
      w = $urandom;
`ifdef INBOUND_CHECKSUM_EN
      if ($urandom_range(0, 1) == 1) w[7:0] = w[31:24] ^ w[23:16] ^ w[15:8];
`endif
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 9) < 8) g[k] = $urandom_range(0, G);
        else                          g[k] = $urandom_range(G + 1, G + 2);
      end
      send_attempt(w, g[0], g[1], g[2], -1);
      for (int i = $urandom_range(0, 2); i > 0; i--) begin
        step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
        chk("in_ready_between", 32'(in_ready), 32'd1);
      end
    end

    repeat (6) step(1'b0, 8'h00, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
